// File: rtl/ccw_chain_sequencer.sv
// Channel-command-word chain sequencer: fetches 64-bit CCWs, starts the channel, evaluates ending status.
// Optional build macro CCW_FETCH_TIMEOUT_EN adds a FETCH watchdog that ends the chain with error_code 6.
module ccw_chain_sequencer #(
  parameter int FETCH_TIMEOUT = 1024
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] caw,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code,
  output logic [31:0] ccw_ptr,
  output logic [7:0]  ccw_command,
  output logic [15:0] ccw_count,
  output logic [31:0] ccw_data_addr,
  output logic        chan_start,
  input  logic [7:0]  chan_status_tdata,
  input  logic        chan_status_tvalid,
  input  logic [15:0] residual_count,
  output logic [7:0]  last_status,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] START    = 3'd3;
  localparam logic [2:0] WAIT_END = 3'd4;
  localparam logic [2:0] EVAL     = 3'd5;

  logic [2:0]  state;
  logic [7:0]  raw_cmd;
  logic        raw_cd;
  logic        raw_cc;
  logic        raw_sli;
  logic [15:0] raw_count;
  logic [31:0] raw_addr;
  logic [31:0] next_ptr;
  logic        fin;
  logic [2:0]  fin_code;
  logic        timeout_hit;
  logic        unused_rdata;

  assign unused_rdata = ^mem_rdata[52:48];
  assign next_ptr = ccw_ptr + (last_status[6] ? 32'd16 : 32'd8);

`ifdef CCW_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
  logic [TO_W-1:0] fetch_cnt;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)
      fetch_cnt <= '0;
    else if (state != FETCH)
      fetch_cnt <= '0;
    else
      fetch_cnt <= fetch_cnt + 1'b1;
  end

  assign timeout_hit = (fetch_cnt == TO_W'(FETCH_TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |FETCH_TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // Chain-ending decision; fin_code 0 is a successful end.
  always_comb begin
    fin      = 1'b0;
    fin_code = 3'd0;
    case (state)
      IDLE: begin
        if (start && caw[2:0] != 3'd0) begin
          fin      = 1'b1;
          fin_code = 3'd7;
        end
      end
      FETCH: begin
        if (mem_ack && mem_err) begin
          fin      = 1'b1;
          fin_code = 3'd1;
        end else if (!mem_ack && timeout_hit) begin
          fin      = 1'b1;
          fin_code = 3'd6;
        end
      end
      DECODE: begin
        if (raw_count == 16'd0) begin
          fin      = 1'b1;
          fin_code = 3'd2;
        end else if (raw_cd) begin
          fin      = 1'b1;
          fin_code = 3'd3;
        end
      end
      EVAL: begin
        if (last_status[1] || last_status[0]) begin
          fin      = 1'b1;
          fin_code = 3'd4;
        end else if (residual_count != 16'd0 && !raw_sli) begin
          fin      = 1'b1;
          fin_code = 3'd5;
        end else if (!raw_cc) begin
          fin      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      error_code    <= 3'd0;
      ccw_ptr       <= 32'd0;
      ccw_command   <= 8'd0;
      ccw_count     <= 16'd0;
      ccw_data_addr <= 32'd0;
      chan_start    <= 1'b0;
      last_status   <= 8'd0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'd0;
      raw_cmd       <= 8'd0;
      raw_cd        <= 1'b0;
      raw_cc        <= 1'b0;
      raw_sli       <= 1'b0;
      raw_count     <= 16'd0;
      raw_addr      <= 32'd0;
    end else begin
      done       <= 1'b0;
      chan_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error       <= 1'b0;
            error_code  <= 3'd0;
            last_status <= 8'd0;
            ccw_ptr     <= caw;
            if (caw[2:0] == 3'd0) begin
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= caw;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_err) begin
              raw_cmd   <= mem_rdata[63:56];
              raw_cd    <= mem_rdata[55];
              raw_cc    <= mem_rdata[54];
              raw_sli   <= mem_rdata[53];
              raw_count <= mem_rdata[47:32];
              raw_addr  <= mem_rdata[31:0];
              state     <= DECODE;
            end
          end
        end
        DECODE: begin
          ccw_command   <= raw_cmd;
          ccw_count     <= raw_count;
          ccw_data_addr <= raw_addr;
          if (!fin) begin
            chan_start <= 1'b1;
            state      <= START;
          end
        end
        START: state <= WAIT_END;
        WAIT_END: begin
          if (chan_status_tvalid) begin
            last_status <= chan_status_tdata;
            if (chan_status_tdata[2] || chan_status_tdata[1])
              state <= EVAL;
          end
        end
        EVAL: begin
          if (!fin) begin
            ccw_ptr  <= next_ptr;
            mem_addr <= next_ptr;
            mem_req  <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
      // Any chain end overrides the per-state updates above.
      if (fin) begin
        state      <= IDLE;
        busy       <= 1'b0;
        done       <= 1'b1;
        mem_req    <= 1'b0;
        error      <= (fin_code != 3'd0);
        error_code <= fin_code;
      end
    end
  end

endmodule

// File: doc/ccw_chain_sequencer.md
CCW_CHAIN_SEQUENCER -- requirements
Module: ccw_chain_sequencer

Interface
REQ-001 The block SHALL have parameter FETCH_TIMEOUT, default 1024, giving the cycles allowed in FETCH before a timeout error (used only with CCW_FETCH_TIMEOUT_EN).
REQ-002 The block SHALL have ports, clock and reset first:
- aclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin chain at caw
- caw  in  32  address of first CCW
- busy  out  1  chain in progress
- done  out  1  one-cycle pulse at chain end (success or error)
- error  out  1  chain ended abnormally
- error_code  out  3  cause, valid while error=1
- ccw_ptr  out  32  address of current CCW
- ccw_command  out  8  decoded command to channel
- ccw_count  out  16  decoded byte count
- ccw_data_addr  out  32  decoded data address
- chan_start  out  1  one-cycle start pulse to channel
- chan_status_tdata  in  8  device status byte
- chan_status_tvalid  in  1  status strobe
- residual_count  in  16  bytes not transferred by last CCW
- last_status  out  8  last device status captured
- mem_req  out  1  64-bit read request
- mem_addr  out  32  read address
- mem_ack  in  1  read complete
- mem_rdata  in  64  read data
- mem_err  in  1  read failed; qualified by mem_ack

Function
REQ-003 The CCW format SHALL be: [63:56] command, [55] CD, [54] CC, [53] SLI, [52:48] ignored, [47:32] count, [31:0] data address.
REQ-004 The states SHALL be IDLE, FETCH, DECODE, START, WAIT_END, EVAL.
REQ-005 In IDLE, start SHALL be accepted only when busy=0; start while busy SHALL be ignored.
REQ-006 An accepted start SHALL clear error, error_code and last_status, load ccw_ptr=caw, set busy and enter FETCH; caw[2:0]!=0 SHALL instead end with error_code 7 and issue no fetch.
REQ-007 In FETCH, mem_req SHALL be 1 with mem_addr=ccw_ptr, stable until the mem_ack cycle; mem_req SHALL drop the cycle after mem_ack.
REQ-008 mem_ack with mem_err=1 SHALL end the chain with error_code 1; otherwise the state SHALL be DECODE.
REQ-009 DECODE (1 cycle) SHALL latch ccw_command/count/data_addr; count==0 SHALL give error_code 2 and CD=1 SHALL give error_code 3 (count check first); otherwise START.
REQ-010 START SHALL assert chan_start for exactly one cycle, then enter WAIT_END.
REQ-011 In WAIT_END, every chan_status_tvalid SHALL update last_status; a status with bit 2 (DE) or bit 1 (UC) set SHALL move to EVAL, others (e.g. 0x08 CE only) SHALL not.
REQ-012 EVAL SHALL apply, in priority order: UC or UE (bit 0) -> error_code 4; residual_count!=0 with SLI=0 -> error_code 5; CC=1 -> ccw_ptr += 8, or += 16 if status bit 6 (SM) set, then FETCH; else successful end.
REQ-013 ccw_ptr arithmetic SHALL be 32-bit modulo 2^32.
REQ-014 Chain end SHALL pulse done for one cycle, clear busy, and return to IDLE; error SHALL hold until the next accepted start.
REQ-015 mem_ack or chan_status_tvalid outside FETCH or WAIT_END respectively SHALL be ignored.

Reset
REQ-016 reset SHALL act asynchronously: state IDLE; busy, done, error, chan_start, mem_req = 0; error_code, last_status, ccw_ptr, ccw_* outputs, mem_addr = 0.
REQ-017 Reset mid-chain SHALL drop mem_req and busy immediately, with no done pulse; reset SHALL win over a simultaneous start.

Configuration
REQ-018 With CCW_FETCH_TIMEOUT_EN defined, a cycle counter SHALL run in FETCH; reaching FETCH_TIMEOUT cycles without mem_ack SHALL drop mem_req and end with error_code 6, and any late mem_ack SHALL be ignored.
REQ-019 Without CCW_FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, no counter SHALL exist, and error_code 6 SHALL never occur.

Verification
REQ-020 Single CCW: caw=0x1000, rdata=0x01000010_20000000 (cmd 0x01, count 0x10, addr 0x2000_0000), status 0x0C, residual 0 -> one chan_start, ccw_count=0x0010, done with error=0.
REQ-021 Chain: CCW@0x1000 with CC=1, then CCW@0x1008 with CC=0, both status 0x0C -> mem_addr 0x1000 then 0x1008, two chan_start pulses, one done.
REQ-022 Status modifier: first CCW CC=1, status 0x4C -> next fetch at 0x1010.
REQ-023 Errors: count=0 -> error_code 2, no chan_start; status 0x0E -> error_code 4; residual 5 with SLI=0 -> error_code 5, and with SLI=1 -> success; caw=0x1004 -> error_code 7.
REQ-024 Reset during FETCH: mem_req falls in the reset cycle, busy=0, no done; a later start runs normally.
REQ-025 With CCW_FETCH_TIMEOUT_EN and FETCH_TIMEOUT=16, no mem_ack -> error_code 6 after 16 cycles; a late ack is ignored.
